// File: rtl/onehot_step_selector.sv
// One-hot channel selector: each rising edge of STEP moves the single active bit one place in the
// sampled direction. It wraps or saturates at the end, and has synchronous clear/load. All outputs are registered.
module onehot_step_selector #(
  parameter int N        = 8,
  parameter int USE_SYNC = 1,
  parameter int IW       = $clog2(N)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          STEP,
  input  logic          DIR,
  input  logic          WRAP,
  input  logic          CLR,
  input  logic          LOAD,
  input  logic [IW-1:0] LOAD_IDX,
  output logic [N-1:0]  O,
  output logic [IW-1:0] IDX,
  output logic          ACTIVE,
  output logic          WRAP_P
);

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [N-1:0]  ONE_BIT  = {{(N-1){1'b0}}, 1'b1};

  logic step_s;
  logic samp_vld;

  // samp_vld marks step_s as a genuine sample of STEP rather than a reset value still in the pipe.
  generate
    if (USE_SYNC != 0) begin : g_sync
      logic s1_q, s2_q, v1_q, v2_q;
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          s1_q <= 1'b0;
          s2_q <= 1'b0;
          v1_q <= 1'b0;
          v2_q <= 1'b0;
        end else begin
          s1_q <= STEP;
          s2_q <= s1_q;
          v1_q <= 1'b1;
          v2_q <= v1_q;
        end
      end
      assign step_s   = s2_q;
      assign samp_vld = v2_q;
    end else begin : g_nosync
      logic s1_q, v1_q;
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          s1_q <= 1'b0;
          v1_q <= 1'b0;
        end else begin
          s1_q <= STEP;
          v1_q <= 1'b1;
        end
      end
      assign step_s   = s1_q;
      assign samp_vld = v1_q;
    end
  endgenerate

  logic prev_q;
  logic armed_q;
  logic step_evt;

  // armed_q stays low until STEP is seen low, so a STEP held through reset release is ignored.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      prev_q <= step_s;
      if (samp_vld && !step_s) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign step_evt = samp_vld & armed_q & step_s & ~prev_q;

  logic [N-1:0]  o_q, o_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          act_q, act_d;
  logic          wrap_q, wrap_d;
  logic          load_oob;

  assign load_oob = ({{(32-IW){1'b0}}, LOAD_IDX} >= 32'(N));

  always_comb begin
    idx_d  = idx_q;
    act_d  = act_q;
    wrap_d = 1'b0;
    if (CLR || (LOAD && load_oob)) begin
      idx_d = '0;
      act_d = 1'b0;
    end else if (LOAD) begin
      idx_d = LOAD_IDX;
      act_d = 1'b1;
    end else if (step_evt) begin
      if (!act_q) begin
        idx_d = DIR ? LAST_IDX : '0;
        act_d = 1'b1;
      end else if (!DIR) begin
        if (idx_q != LAST_IDX) begin
          idx_d = idx_q + 1'b1;
        end else if (WRAP) begin
          idx_d  = '0;
          wrap_d = 1'b1;
        end
      end else begin
        if (idx_q != '0) begin
          idx_d = idx_q - 1'b1;
        end else if (WRAP) begin
          idx_d  = LAST_IDX;
          wrap_d = 1'b1;
        end
      end
    end
    o_d = act_d ? (ONE_BIT << idx_d) : '0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      o_q    <= '0;
      idx_q  <= '0;
      act_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      o_q    <= o_d;
      idx_q  <= idx_d;
      act_q  <= act_d;
      wrap_q <= wrap_d;
    end
  end

  assign O      = o_q;
  assign IDX    = idx_q;
  assign ACTIVE = act_q;
  assign WRAP_P = wrap_q;

endmodule

// File: tb/tb_onehot_step_selector.sv
// Bench for onehot_step_selector: N=8 with synchroniser, plus N=3 without synchroniser.
module tb_onehot_step_selector;

  localparam logic [1:0] OP_STEP = 2'd0;
  localparam logic [1:0] OP_LOAD = 2'd1;
  localparam logic [1:0] OP_CLR  = 2'd2;
  localparam logic [1:0] OP_LDCL = 2'd3;

  typedef struct {
    logic [1:0] op;
    logic       dir;
    logic       wrap;
    logic [2:0] ld;
    logic [7:0] o;
    logic [2:0] idx;
    logic       act;
    logic       wp;
  } vec_t;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       STEP, DIR, WRAP, CLR, LOAD;
  logic [2:0] ld8;
  logic [1:0] ld3;
  logic [7:0] o8;
  logic [2:0] idx8;
  logic       act8, wp8;
  logic [2:0] o3;
  logic [1:0] idx3;
  logic       act3, wp3;

  logic       use3;
  logic [7:0] cur_o;
  logic [2:0] cur_idx;
  logic       cur_act, cur_wp;

  int checks = 0;
  int errors = 0;

  logic [7:0] e_o;
  logic [2:0] e_idx;
  logic       e_act;

  vec_t tbl[40];
  int   ntbl = 0;

  always #5 CLK = ~CLK;

  onehot_step_selector #(.N(8), .USE_SYNC(1)) u8 (
    .CLK(CLK), .RST_N(RST_N), .STEP(STEP), .DIR(DIR), .WRAP(WRAP), .CLR(CLR), .LOAD(LOAD),
    .LOAD_IDX(ld8), .O(o8), .IDX(idx8), .ACTIVE(act8), .WRAP_P(wp8)
  );

  onehot_step_selector #(.N(3), .USE_SYNC(0)) u3 (
    .CLK(CLK), .RST_N(RST_N), .STEP(STEP), .DIR(DIR), .WRAP(WRAP), .CLR(CLR), .LOAD(LOAD),
    .LOAD_IDX(ld3), .O(o3), .IDX(idx3), .ACTIVE(act3), .WRAP_P(wp3)
  );

  always_comb begin
    cur_o   = use3 ? {5'b0, o3} : o8;
    cur_idx = use3 ? {1'b0, idx3} : idx8;
    cur_act = use3 ? act3 : act8;
    cur_wp  = use3 ? wp3 : wp8;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic add(input logic [1:0] op, input logic dir, input logic wrap, input logic [2:0] ld,
                     input logic [7:0] o, input logic [2:0] idx, input logic act, input logic wp);
    tbl[ntbl] = '{op, dir, wrap, ld, o, idx, act, wp};
    ntbl++;
  endtask

  task automatic chk_all(input string nm, input logic [7:0] o, input logic [2:0] idx,
                         input logic act, input logic wp);
    chk({nm, ".o"}, 32'(cur_o), 32'(o));
    chk({nm, ".idx"}, 32'(cur_idx), 32'(idx));
    chk({nm, ".act"}, 32'(cur_act), 32'(act));
    chk({nm, ".wp"}, 32'(cur_wp), 32'(wp));
  endtask

  // STEP high for 4 cycles then low for 4; the update must land exactly lat edges after the rise.
  task automatic do_step(input int lat, input logic [7:0] o, input logic [2:0] idx,
                         input logic act, input logic wp, input string nm);
    STEP = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k < lat) begin
        chk({nm, ".early_o"}, 32'(cur_o), 32'(e_o));
        chk({nm, ".early_wp"}, 32'(cur_wp), 32'd0);
      end
      if (k == lat) chk_all(nm, o, idx, act, wp);
      if (k == lat + 1) begin
        chk({nm, ".wp_after"}, 32'(cur_wp), 32'd0);
        chk({nm, ".hold_o"}, 32'(cur_o), 32'(o));
      end
    end
    STEP = 1'b0;
    repeat (4) tick();
    e_o = o; e_idx = idx; e_act = act;
  endtask

  task automatic pulse_load(input logic clr_too, input logic [2:0] ld);
    LOAD = 1'b1;
    CLR  = clr_too;
    ld8  = ld;
    ld3  = ld[1:0];
    tick();
    LOAD = 1'b0;
    CLR  = 1'b0;
  endtask

  initial begin
    vec_t v;
    int   nchg;
    logic [7:0] prev;

    for (int i = 0; i < 8; i++) add(OP_STEP, 1'b0, 1'b1, 3'd0, 8'(8'h01 << i), 3'(i), 1'b1, 1'b0);
    add(OP_STEP, 1'b0, 1'b1, 3'd0, 8'h01, 3'd0, 1'b1, 1'b1);
    add(OP_CLR,  1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) add(OP_STEP, 1'b1, 1'b0, 3'd0, 8'(8'h80 >> i), 3'(7 - i), 1'b1, 1'b0);
    add(OP_STEP, 1'b1, 1'b0, 3'd0, 8'h01, 3'd0, 1'b1, 1'b0);
    add(OP_LOAD, 1'b0, 1'b0, 3'd5, 8'h20, 3'd5, 1'b1, 1'b0);
    add(OP_LDCL, 1'b0, 1'b0, 3'd3, 8'h00, 3'd0, 1'b0, 1'b0);
    add(OP_LOAD, 1'b0, 1'b0, 3'd7, 8'h80, 3'd7, 1'b1, 1'b0);
    add(OP_STEP, 1'b0, 1'b0, 3'd0, 8'h80, 3'd7, 1'b1, 1'b0);
    add(OP_LOAD, 1'b0, 1'b0, 3'd0, 8'h01, 3'd0, 1'b1, 1'b0);
    add(OP_STEP, 1'b1, 1'b1, 3'd0, 8'h80, 3'd7, 1'b1, 1'b1);
    add(OP_STEP, 1'b1, 1'b1, 3'd0, 8'h40, 3'd6, 1'b1, 1'b0);
    add(OP_CLR,  1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 1'b0, 1'b0);

    use3 = 1'b0;
    RST_N = 1'b0; STEP = 1'b0; DIR = 1'b0; WRAP = 1'b1; CLR = 1'b0; LOAD = 1'b0;
    ld8 = 3'd0; ld3 = 2'd0;
    e_o = 8'h00; e_idx = 3'd0; e_act = 1'b0;
    tick(); tick();
    chk_all("reset8", 8'h00, 3'd0, 1'b0, 1'b0);
    RST_N = 1'b1;
    repeat (3) tick();
    chk_all("idle8", 8'h00, 3'd0, 1'b0, 1'b0);

    for (int i = 0; i < ntbl; i++) begin
      v = tbl[i];
      DIR  = v.dir;
      WRAP = v.wrap;
      case (v.op)
        OP_STEP: do_step(3, v.o, v.idx, v.act, v.wp, $sformatf("vec%0d", i));
        OP_LOAD: begin
          pulse_load(1'b0, v.ld);
          chk_all($sformatf("vec%0d", i), v.o, v.idx, v.act, v.wp);
        end
        OP_CLR: begin
          CLR = 1'b1;
          tick();
          CLR = 1'b0;
          chk_all($sformatf("vec%0d", i), v.o, v.idx, v.act, v.wp);
        end
        default: begin
          pulse_load(1'b1, v.ld);
          chk_all($sformatf("vec%0d", i), v.o, v.idx, v.act, v.wp);
        end
      endcase
      e_o = v.o; e_idx = v.idx; e_act = v.act;
    end

    // Step event coincides with LOAD: the load wins and the step is dropped.
    DIR = 1'b0; WRAP = 1'b1;
    STEP = 1'b1;
    tick(); tick();
    pulse_load(1'b0, 3'd2);
    chk_all("coinc", 8'h04, 3'd2, 1'b1, 1'b0);
    tick();
    chk("coinc.later", 32'(cur_o), 32'h04);
    STEP = 1'b0;
    repeat (4) tick();
    chk("coinc.lost", 32'(cur_o), 32'h04);
    e_o = 8'h04; e_idx = 3'd2; e_act = 1'b1;

    STEP = 1'b1;
    nchg = 0;
    prev = cur_o;
    repeat (20) begin
      tick();
      if (cur_o !== prev) nchg++;
      prev = cur_o;
    end
    chk("held.count", 32'(nchg), 32'd1);
    chk("held.o", 32'(cur_o), 32'h08);
    STEP = 1'b0;
    repeat (4) tick();
    e_o = 8'h08; e_idx = 3'd3; e_act = 1'b1;

    do_step(3, 8'h10, 3'd4, 1'b1, 1'b0, "pre_arst");
    @(posedge CLK);
    #3 RST_N = 1'b0;
    #1 chk_all("arst", 8'h00, 3'd0, 1'b0, 1'b0);
    #2 RST_N = 1'b1;
    tick(); tick();
    e_o = 8'h00; e_idx = 3'd0; e_act = 1'b0;
    do_step(3, 8'h01, 3'd0, 1'b1, 1'b0, "post_arst");

    RST_N = 1'b0;
    STEP  = 1'b1;
    repeat (3) tick();
    RST_N = 1'b1;
    repeat (10) tick();
    chk_all("held_rst", 8'h00, 3'd0, 1'b0, 1'b0);
    STEP = 1'b0;
    repeat (4) tick();
    chk("held_rst.low", 32'(cur_o), 32'h00);
    e_o = 8'h00; e_idx = 3'd0; e_act = 1'b0;
    do_step(3, 8'h01, 3'd0, 1'b1, 1'b0, "held_rst.step");

    use3 = 1'b1;
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    tick(); tick();
    chk_all("reset3", 8'h00, 3'd0, 1'b0, 1'b0);
    e_o = 8'h00; e_idx = 3'd0; e_act = 1'b0;
    DIR = 1'b0; WRAP = 1'b1;
    do_step(2, 8'h01, 3'd0, 1'b1, 1'b0, "n3_s0");
    do_step(2, 8'h02, 3'd1, 1'b1, 1'b0, "n3_s1");
    do_step(2, 8'h04, 3'd2, 1'b1, 1'b0, "n3_s2");
    do_step(2, 8'h01, 3'd0, 1'b1, 1'b1, "n3_wrap");
    pulse_load(1'b0, 3'd3);
    chk_all("n3_load_oob", 8'h00, 3'd0, 1'b0, 1'b0);
    pulse_load(1'b0, 3'd2);
    chk_all("n3_load2", 8'h04, 3'd2, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
